// File: rtl/t03_player_1_motion_if.sv
// Player-1 motion bus: VGA counters and buttons in, sprite offset and status out.
// master drives the counters and buttons; slave is the motion block.
interface t03_player_1_motion_if;
    logic [10:0] Hcnt;
    logic [10:0] Vcnt;
    logic        btn_left;
    logic        btn_right;
    logic        btn_jump;
    logic        enable;
    logic [10:0] x;
    logic [10:0] y;
    logic        facing;
    logic [1:0]  state;
    logic        frame_tick;

    modport master (
        output Hcnt, Vcnt, btn_left, btn_right, btn_jump, enable,
        input  x, y, facing, state, frame_tick
    );

    modport slave (
        input  Hcnt, Vcnt, btn_left, btn_right, btn_jump, enable,
        output x, y, facing, state, frame_tick
    );
endinterface

// File: rtl/t03_player_1_motion.sv
// Player-1 sprite motion: walking, jump/gravity FSM and screen clamping,
// updated once per frame on the first blanking line.
module t03_player_1_motion #(
    parameter logic [10:0] TICK_LINE  = 11'd481,
    parameter logic [10:0] X_START    = 11'd100,
    parameter logic [10:0] X_MAX      = 11'd580,
    parameter logic [10:0] GROUND_Y   = 11'd300,
    parameter logic [10:0] Y_MIN      = 11'd0,
    parameter logic [3:0]  WALK_SPEED = 4'd3,
    parameter logic [4:0]  JUMP_V     = 5'd12,
    parameter logic [2:0]  GRAVITY    = 3'd1,
    parameter logic [4:0]  MAX_FALL   = 5'd12
) (
    input logic clk,
    input logic rst,
    t03_player_1_motion_if.slave bus
);

    localparam logic signed [11:0] WALK_S   = {8'd0, WALK_SPEED};
    localparam logic signed [11:0] JUMP_S   = {7'd0, JUMP_V};
    localparam logic signed [11:0] X_MAX_S  = {1'b0, X_MAX};
    localparam logic signed [11:0] GROUND_S = {1'b0, GROUND_Y};
    localparam logic signed [11:0] Y_MIN_S  = {1'b0, Y_MIN};
    localparam logic signed [5:0]  VY_JUMP  = -$signed({1'b0, JUMP_V});
    localparam logic signed [6:0]  GRAV_S   = {4'd0, GRAVITY};
    localparam logic signed [6:0]  FALL_S   = {2'd0, MAX_FALL};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        JUMP = 2'd2,
        FALL = 2'd3
    } state_t;

    function automatic logic [10:0] clamp_x(input logic signed [11:0] v);
        logic [10:0] r;
        if (v < 12'sd0)
            r = 11'd0;
        else if (v > X_MAX_S)
            r = X_MAX;
        else
            r = v[10:0];
        return r;
    endfunction

    function automatic logic signed [5:0] sat_fall(input logic signed [6:0] v);
        logic signed [5:0] r;
        if (v > FALL_S)
            r = FALL_S[5:0];
        else
            r = v[5:0];
        return r;
    endfunction

    logic              left_p0, left_p1;
    logic              right_p0, right_p1;
    logic              jump_p0, jump_p1, jump_p2;
    logic              jump_pending;
    logic              update;
    state_t            st;
    logic [10:0]       x_q, y_q;
    logic signed [5:0] vy_q;
    logic              facing_q;
    logic              tick_q;

    logic              lonly, ronly;
    logic [10:0]       x_walk;
    logic              facing_walk;
    state_t            ground_st;
    logic signed [6:0] vy_sum;
    logic signed [5:0] vy_fall;
    logic signed [11:0] y_fall;
    logic signed [11:0] y_up;

    assign update = (bus.Vcnt == TICK_LINE) && (bus.Hcnt == 11'd0);

    always_comb begin
        lonly       = left_p1 & ~right_p1;
        ronly       = right_p1 & ~left_p1;
        x_walk      = x_q;
        facing_walk = facing_q;
        if (lonly) begin
            x_walk      = clamp_x($signed({1'b0, x_q}) - WALK_S);
            facing_walk = 1'b1;
        end else if (ronly) begin
            x_walk      = clamp_x($signed({1'b0, x_q}) + WALK_S);
            facing_walk = 1'b0;
        end
        ground_st = (lonly | ronly) ? WALK : IDLE;
        vy_sum    = 7'(vy_q) + GRAV_S;
        vy_fall   = sat_fall(vy_sum);
        y_fall    = $signed({1'b0, y_q}) + 12'(vy_fall);
        y_up      = $signed({1'b0, y_q}) - JUMP_S;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_p0      <= 1'b0;
            left_p1      <= 1'b0;
            right_p0     <= 1'b0;
            right_p1     <= 1'b0;
            jump_p0      <= 1'b0;
            jump_p1      <= 1'b0;
            jump_p2      <= 1'b0;
            jump_pending <= 1'b0;
            st           <= IDLE;
            x_q          <= X_START;
            y_q          <= GROUND_Y;
            vy_q         <= '0;
            facing_q     <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            // p0/p1: button synchronizers; p2 holds the previous jump level for edge detect
            left_p0  <= bus.btn_left;
            left_p1  <= left_p0;
            right_p0 <= bus.btn_right;
            right_p1 <= right_p0;
            jump_p0  <= bus.btn_jump;
            jump_p1  <= jump_p0;
            jump_p2  <= jump_p1;
            tick_q   <= update;

            // A latched press is consumed (or discarded) by every update, enabled or not
            if (update)
                jump_pending <= 1'b0;
            else if (jump_p1 & ~jump_p2)
                jump_pending <= 1'b1;

            if (update && bus.enable) begin
                x_q      <= x_walk;
                facing_q <= facing_walk;
                case (st)
                    IDLE, WALK: begin
                        if (jump_pending) begin
                            vy_q <= VY_JUMP;
                            y_q  <= y_up[10:0];
                            st   <= JUMP;
                        end else begin
                            y_q <= GROUND_Y;
                            st  <= ground_st;
                        end
                    end
                    default: begin
                        if (y_fall >= GROUND_S) begin
                            y_q  <= GROUND_Y;
                            vy_q <= '0;
                            st   <= ground_st;
                        end else if (y_fall < Y_MIN_S) begin
                            y_q  <= Y_MIN;
                            vy_q <= '0;
                            st   <= FALL;
                        end else begin
                            y_q  <= y_fall[10:0];
                            vy_q <= vy_fall;
                            st   <= (vy_fall < 6'sd0) ? JUMP : FALL;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.facing     = facing_q;
    assign bus.state      = st;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_t03_player_1_motion.sv
// Randomized and directed bench for t03_player_1_motion against a per-frame
// behavioural model of walking, jumping, gravity and clamping.
module tb_t03_player_1_motion;

    logic clk = 1'b0;
    logic rst = 1'b0;

    t03_player_1_motion_if bus ();

    t03_player_1_motion dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: x, y, vertical speed, state code (0..3), facing
    int mx, my, mvy, ms, mf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 100; my = 300; mvy = 0; ms = 0; mf = 0;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit j, input bit en);
        bit lo, ro;
        int nv, ny;
        if (!en) return;
        lo = l && !r;
        ro = r && !l;
        if (lo) begin
            mx = (mx - 3 < 0) ? 0 : mx - 3;
            mf = 1;
        end else if (ro) begin
            mx = (mx + 3 > 580) ? 580 : mx + 3;
            mf = 0;
        end
        if (ms < 2) begin
            if (j) begin
                mvy = -12; my = my - 12; ms = 2;
            end else begin
                my = 300; ms = (lo || ro) ? 1 : 0;
            end
        end else begin
            nv = (mvy + 1 > 12) ? 12 : mvy + 1;
            ny = my + nv;
            if (ny >= 300) begin
                my = 300; mvy = 0; ms = (lo || ro) ? 1 : 0;
            end else if (ny < 0) begin
                my = 0; mvy = 0; ms = 3;
            end else begin
                my = ny; mvy = nv; ms = (nv < 0) ? 2 : 3;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_x"}, 32'(bus.x), mx);
        chk({tag, "_y"}, 32'(bus.y), my);
        chk({tag, "_state"}, 32'(bus.state), ms);
        chk({tag, "_facing"}, 32'(bus.facing), mf);
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        chk({tag, "_tick"}, 32'(bus.frame_tick), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One reduced frame: lines 476..485, four pixels each; only (481,0) is an update edge
    task automatic do_frame(input bit l, input bit r, input bit j, input bit en);
        int cyc = 0;
        int seen = 0;
        bus.btn_left  = l;
        bus.btn_right = r;
        bus.enable    = en;
        for (int v = 476; v <= 485; v++) begin
            for (int h = 0; h < 4; h++) begin
                @(negedge clk);
                bus.Hcnt = 11'(h);
                bus.Vcnt = 11'(v);
                if (cyc == 0 && j)
                    bus.btn_jump = 1'b1;
                else if (cyc == 2)
                    bus.btn_jump = 1'b0;
                cyc++;
                @(posedge clk);
                #1;
                seen += int'(bus.frame_tick);
                if (v == 481 && h == 0) begin
                    model_tick(l, r, j, en);
                    chk("tick_pulse", 32'(bus.frame_tick), 1);
                    check_outputs("upd");
                end else begin
                    chk("tick_quiet", 32'(bus.frame_tick), 0);
                end
            end
        end
        chk("ticks_per_frame", seen, 1);
        check_outputs("hold");
    endtask

    initial begin
        int land;
        int peak;
        bus.Hcnt      = '0;
        bus.Vcnt      = '0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_jump  = 1'b0;
        bus.enable    = 1'b1;
        model_reset();

        reset_check("rst0");

        // Walk right, then release
        repeat (3) do_frame(1'b0, 1'b1, 1'b0, 1'b1);
        chk("walk_x", 32'(bus.x), 109);
        chk("walk_state", 32'(bus.state), 1);
        do_frame(1'b0, 1'b0, 1'b0, 1'b1);
        chk("release_state", 32'(bus.state), 0);
        chk("release_x", 32'(bus.x), 109);

        // Full jump arc
        do_frame(1'b0, 1'b0, 1'b1, 1'b1);
        chk("takeoff_y", 32'(bus.y), 288);
        chk("takeoff_state", 32'(bus.state), 2);
        land = 0;
        peak = 300;
        for (int i = 0; i < 40 && bus.state != 2'd0; i++) begin
            do_frame(1'b0, 1'b0, 1'b0, 1'b1);
            if (int'(bus.y) < peak) peak = int'(bus.y);
            land++;
        end
        chk("peak_y", peak, 222);
        chk("land_ticks", land, 24);
        chk("land_y", 32'(bus.y), 300);

        // Both buttons during a jump, then a second press while falling
        do_frame(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (12) do_frame(1'b1, 1'b1, 1'b0, 1'b1);
        chk("both_x", 32'(bus.x), 109);
        chk("apex_state", 32'(bus.state), 3);
        do_frame(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (15) do_frame(1'b0, 1'b0, 1'b0, 1'b1);
        chk("dbl_landed", 32'(bus.state), 0);

        // Freeze mid-jump; a press while frozen is dropped
        do_frame(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) do_frame(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (2) do_frame(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (26) do_frame(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a jump
        do_frame(1'b0, 1'b1, 1'b1, 1'b1);
        do_frame(1'b0, 1'b1, 1'b0, 1'b1);
        reset_check("rst_mid");

        // Screen clamps
        repeat (40) do_frame(1'b1, 1'b0, 1'b0, 1'b1);
        chk("lclamp_x", 32'(bus.x), 0);
        chk("lclamp_facing", 32'(bus.facing), 1);
        repeat (200) do_frame(1'b0, 1'b1, 1'b0, 1'b1);
        chk("rclamp_x", 32'(bus.x), 580);
        chk("rclamp_facing", 32'(bus.facing), 0);

        // Random play
        for (int i = 0; i < 150; i++) begin
            do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 9) < 3, $urandom_range(0, 9) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/t03_player_1_motion.md
Name: t03_player_1_motion

Overview:
- Upstream stage of the player-1 sprite renderer. Computes player 1's sprite offset (x, y) once per video frame from the left/right/jump buttons.
- Implements walking, a jump/gravity state machine, and screen-bound clamping.
- The renderer adds its fixed screen margins (37, 29) to x and y, so this block outputs raw offsets only.
- Hcnt/Vcnt come from the VGA timing generator and are used only to derive a once-per-frame update tick.

Parameters:
- TICK_LINE, 11'd481: Vcnt value at which the per-frame update fires (first blanking line).
- X_START, 11'd100: x after reset.
- X_MAX, 11'd580: largest legal x. Legal x range is 0..X_MAX.
- GROUND_Y, 11'd300: resting y. y grows downward.
- Y_MIN, 11'd0: smallest legal y (ceiling).
- WALK_SPEED, 4'd3: pixels per frame of horizontal motion.
- JUMP_V, 5'd12: initial upward speed, in pixels per frame.
- GRAVITY, 3'd1: added to vertical velocity every frame while airborne.
- MAX_FALL, 5'd12: downward velocity clamp.

Ports:
- clk, input, 1: pixel clock.
- rst, input, 1: asynchronous, active-high reset.
- Hcnt, input, 11: horizontal pixel counter.
- Vcnt, input, 11: vertical line counter.
- btn_left, input, 1: asynchronous button, active-high.
- btn_right, input, 1: asynchronous button, active-high.
- btn_jump, input, 1: asynchronous button, active-high.
- enable, input, 1: 0 freezes all motion. Button capture continues.
- x, output, 11: sprite x offset.
- y, output, 11: sprite y offset.
- facing, output, 1: 0 = right, 1 = left.
- state, output, 2: 0 IDLE, 1 WALK, 2 JUMP (rising), 3 FALL.
- frame_tick, output, 1: one-cycle pulse, high the cycle in which the new x/y first appear.

Behaviour:
- Reset is asynchronous: clk is clock, rst is async active-high reset. Reset values:
  - x = X_START, y = GROUND_Y, vy = 0.
  - state = IDLE, facing = 0, frame_tick = 0.
  - All synchronizer and pending flops = 0.
- Reset mid-jump returns to the reset values immediately, with no partial update.
- Input synchronization: each button passes through a 2-FF synchronizer.
  - jump_pending is set on a rising edge of the synchronized jump (level 0→1).
  - jump_pending is cleared at every update edge.
  - A press and release shorter than one frame is still honoured.
- Update edge: the clk edge where Vcnt == TICK_LINE && Hcnt == 0. This happens exactly once per frame.
  - All motion registers update on this edge.
  - frame_tick is 1 for the following cycle only.
  - The cycle after any update edge never matches again.
- enable = 0 at an update edge: x, y, vy, state and facing hold. frame_tick still pulses and jump_pending still clears.
- Horizontal, evaluated at each enabled update edge in all states:
  - Left only: x = max(x − WALK_SPEED, 0), facing = 1.
  - Right only: x = min(x + WALK_SPEED, X_MAX), facing = 0.
  - Both or neither pressed: x holds and facing holds.
  - Arithmetic uses a 12-bit signed intermediate; underflow clamps to 0.
- Vertical FSM, evaluated at each enabled update edge:
  - IDLE/WALK with jump_pending: vy = −JUMP_V, y = y − JUMP_V, go to JUMP.
  - IDLE/WALK without jump_pending: go to WALK if exactly one direction is pressed, otherwise IDLE. y = GROUND_Y.
  - JUMP/FALL: vy_new = min(vy + GRAVITY, MAX_FALL), then y_new = y + vy_new.
    - If y_new ≥ GROUND_Y: y = GROUND_Y, vy = 0, go to WALK/IDLE using the direction rule above. A jump_pending on the landing edge is ignored.
    - Else if y_new < Y_MIN: y = Y_MIN, vy = 0, go to FALL.
    - Else go to JUMP if vy_new < 0, or FALL if vy_new ≥ 0.
  - A jump_pending in JUMP/FALL is discarded (no double jump).
- vy is an internal 6-bit signed register. y arithmetic uses 12-bit signed values.
- Outputs x, y, state and facing are registered and stable between update edges, so the renderer sees constant values for the whole visible frame.

Test Plan:
- Reset: assert rst mid-frame → x = 100, y = 300, state = 0, facing = 0, frame_tick = 0 immediately and without a clock edge.
- Walk right: hold btn_right for 3 frames → x = 103, 106, 109 on successive frame_tick pulses, state = 1. Release → state = 0 on the next tick with x = 109.
- Left clamp: x = 2, hold btn_left → next tick x = 0, facing = 1. Further ticks keep x = 0. Right clamp: x = 579, hold right → x = 580 and stays.
- Jump arc: 2-cycle btn_jump pulse between ticks → first tick y = 288, state = 2. vy steps −11..−1, then y climbs to peak 222 and state = 3. Landing tick: y = 300, state = 0, at the 24th tick after the press.
- Double jump and both buttons: pulse jump while state = 3 → trajectory unchanged. Hold left + right during a jump → x unchanged, facing unchanged.
- Freeze and tick timing: enable = 0 for 2 frames mid-jump → x, y, vy unchanged, frame_tick still pulses. Check frame_tick is exactly 1 cycle wide and occurs exactly once per Vcnt = 481 line.
